fetch_redirect_arbiter: RTL
===========================

# fetch_redirect_arbiter

Fetch-stage controller that drives the program counter input select mux and the PC register write enable. It arbitrates redirect requests from decode (jump), execute (branch mispredict) and the trap unit against sequential fetch. It holds redirects that arrive while fetch is stalled and sequences boot and halt. All outputs are registered.

## Interface
- ADDR_WIDTH, 32, width of all PC/target values
- RESET_VECTOR, 32'h0000_0000, PC loaded after reset
- COUNT_WIDTH, 16, perf counter width (used only with FETCH_REDIRECT_PERF_EN)

- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- stall  in  1  fetch stall (icache miss / decode backpressure); PC must not load
- halt_req  in  1  level; request fetch halt
- jump_req  in  1  decode-stage jump redirect, single-cycle pulse
- jump_target  in  ADDR_WIDTH  jump target
- br_req  in  1  execute-stage mispredict redirect, pulse
- br_target  in  ADDR_WIDTH  corrected target
- trap_req  in  1  trap/exception redirect, pulse
- trap_target  in  ADDR_WIDTH  trap vector
- pc_load  out  1  PC register write enable
- pc_sel  out  3  mux select: 0 SEQ (PC+4), 1 JUMP, 2 BRANCH, 3 TRAP, 4 RESET
- pc_target  out  ADDR_WIDTH  redirect address to mux (0 when pc_sel=SEQ)
- flush  out  1  kill younger IF/ID contents; high exactly when pc_load and pc_sel≠SEQ
- halted  out  1  fetch halted

## Operation
- Priority: TRAP > BRANCH > JUMP > SEQ.
- Pending registers: one valid bit and one target per source. Candidate set each cycle = incoming requests OR pending.
- States:
  - BOOT (entered on reset): next cycle issue pc_sel=RESET, target=RESET_VECTOR, pc_load=1, flush=1. Then go to RUN. Stall is ignored in BOOT.
  - RUN, not stalled: issue highest-priority candidate. If there is none, issue SEQ with pc_load=1. Clear all pending.
  - RUN, stalled: pc_load=0, flush=0, pc_sel=SEQ. Latch incoming requests into pending. An incoming or pending higher-priority request clears all lower-priority pending entries, because it makes their younger instructions dead. A new request from a source that already has a pending entry overwrites that entry's target.
  - HALT: entered from RUN when halt_req=1 and stall=0. On the entry cycle the selected candidate is still issued. From then on, pc_load=0 and halted=1, and requests keep latching using the stalled rules. Return to RUN when halt_req=0. The first RUN cycle issues any pending redirect.
- Reset mid-operation clears all pending entries and returns to BOOT.

## Timing
- Reset values: pc_load=0, pc_sel=0, pc_target=0, flush=0, halted=0, all pending cleared, state BOOT.
- Latency: a request sampled at edge N, with no stall, appears on the outputs after edge N+1. One-cycle latency.
- A stalled request issues in the first cycle with stall=0. Its output appears after the edge at which stall is sampled low.
- flush is a single-cycle pulse per issued redirect. Back-to-back redirects produce back-to-back pulses.
- Simultaneous requests: only the winner issues. Losers are dropped, not held.
- Simultaneous stall deassert with a new higher-priority incoming request: the incoming request wins over pending.

## Configuration
- FETCH_REDIRECT_PERF_EN:
  - Defined: adds outputs perf_jump_cnt, perf_br_cnt and perf_trap_cnt (each COUNT_WIDTH). Each counts issued redirects per source, saturates at all-ones, and resets to 0. Dropped or overwritten requests are not counted.
  - Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then release → cycle after release: pc_load=1, pc_sel=4, pc_target=RESET_VECTOR, flush=1. Following cycles: pc_sel=0, pc_load=1, flush=0.
- jump_req with target 0x100, no stall → next cycle pc_sel=1, pc_target=0x100, flush=1. Cycle after that: SEQ.
- Same cycle: jump_req (0x100), br_req (0x200), trap_req (0x300) → pc_sel=3, target 0x300. No later jump or branch issue.
- stall=1 for 4 cycles, jump_req (0x100) in cycle 1, br_req (0x200) in cycle 3 → pc_load=0 throughout the stall. First cycle after stall: pc_sel=2, target 0x200, then SEQ (jump discarded).
- halt_req=1 for 5 cycles with trap_req (0x80) mid-halt → halted=1, pc_load=0. After halt_req falls: pc_sel=3, target 0x80, flush=1, halted=0.
- With FETCH_REDIRECT_PERF_EN and COUNT_WIDTH=2: issue 5 jumps → perf_jump_cnt=3 (saturated). Reset mid-sequence → 0.

Source files
------------

// File: rtl/fetch_redirect_arbiter_if.sv
// Handshake bundle between the fetch redirect arbiter and its redirect sources / PC mux.
// Perf counter signals exist only when FETCH_REDIRECT_PERF_EN is defined.
interface fetch_redirect_arbiter_if #(
    parameter int ADDR_WIDTH = 32
`ifdef FETCH_REDIRECT_PERF_EN
    ,
    parameter int COUNT_WIDTH = 16
`endif
);
    logic                  stall;
    logic                  halt_req;
    logic                  jump_req;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic                  br_req;
    logic [ADDR_WIDTH-1:0] br_target;
    logic                  trap_req;
    logic [ADDR_WIDTH-1:0] trap_target;
    logic                  pc_load;
    logic [2:0]            pc_sel;
    logic [ADDR_WIDTH-1:0] pc_target;
    logic                  flush;
    logic                  halted;
`ifdef FETCH_REDIRECT_PERF_EN
    logic [COUNT_WIDTH-1:0] perf_jump_cnt;
    logic [COUNT_WIDTH-1:0] perf_br_cnt;
    logic [COUNT_WIDTH-1:0] perf_trap_cnt;

    modport master (
        output stall, halt_req, jump_req, jump_target, br_req, br_target, trap_req, trap_target,
        input  pc_load, pc_sel, pc_target, flush, halted,
        input  perf_jump_cnt, perf_br_cnt, perf_trap_cnt
    );
    modport slave (
        input  stall, halt_req, jump_req, jump_target, br_req, br_target, trap_req, trap_target,
        output pc_load, pc_sel, pc_target, flush, halted,
        output perf_jump_cnt, perf_br_cnt, perf_trap_cnt
    );
`else
    modport master (
        output stall, halt_req, jump_req, jump_target, br_req, br_target, trap_req, trap_target,
        input  pc_load, pc_sel, pc_target, flush, halted
    );
    modport slave (
        input  stall, halt_req, jump_req, jump_target, br_req, br_target, trap_req, trap_target,
        output pc_load, pc_sel, pc_target, flush, halted
    );
`endif
endinterface

// File: rtl/fetch_redirect_arbiter.sv
// Fetch-stage PC select / load controller: prioritises trap > branch > jump > sequential,
// holds redirects across stalls and halt, sequences boot. Optional FETCH_REDIRECT_PERF_EN adds counters.
module fetch_redirect_arbiter #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = {ADDR_WIDTH{1'b0}}
`ifdef FETCH_REDIRECT_PERF_EN
    ,
    parameter int                    COUNT_WIDTH  = 16
`endif
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    fetch_redirect_arbiter_if.slave  io_bus
);
    localparam logic [2:0] SEL_SEQ   = 3'd0;
    localparam logic [2:0] SEL_JUMP  = 3'd1;
    localparam logic [2:0] SEL_BR    = 3'd2;
    localparam logic [2:0] SEL_TRAP  = 3'd3;
    localparam logic [2:0] SEL_RESET = 3'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_pend_jump, r_pend_br, r_pend_trap;
    logic [ADDR_WIDTH-1:0] r_pend_jump_tgt, r_pend_br_tgt, r_pend_trap_tgt;
    logic                  w_pend_jump_nxt, w_pend_br_nxt, w_pend_trap_nxt;
    logic [ADDR_WIDTH-1:0] w_pend_jump_tgt_nxt, w_pend_br_tgt_nxt, w_pend_trap_tgt_nxt;
    logic                  r_pc_load, w_pc_load_nxt;
    logic [2:0]            r_pc_sel, w_pc_sel_nxt;
    logic [ADDR_WIDTH-1:0] r_pc_target, w_pc_target_nxt;
    logic                  r_flush, w_flush_nxt;
    logic                  r_halted, w_halted_nxt;

    logic                  w_cand_jump, w_cand_br, w_cand_trap;
    logic [ADDR_WIDTH-1:0] w_cand_jump_tgt, w_cand_br_tgt, w_cand_trap_tgt;
    logic [2:0]            w_win_sel;
    logic [ADDR_WIDTH-1:0] w_win_tgt;

    // Candidate set (incoming OR pending, incoming target newer) and priority winner
    always_comb begin
        w_cand_jump     = io_bus.jump_req | r_pend_jump;
        w_cand_br       = io_bus.br_req   | r_pend_br;
        w_cand_trap     = io_bus.trap_req | r_pend_trap;
        w_cand_jump_tgt = io_bus.jump_req ? io_bus.jump_target : r_pend_jump_tgt;
        w_cand_br_tgt   = io_bus.br_req   ? io_bus.br_target   : r_pend_br_tgt;
        w_cand_trap_tgt = io_bus.trap_req ? io_bus.trap_target : r_pend_trap_tgt;
        w_win_sel       = SEL_SEQ;
        w_win_tgt       = {ADDR_WIDTH{1'b0}};
        if (w_cand_trap) begin
            w_win_sel = SEL_TRAP;
            w_win_tgt = w_cand_trap_tgt;
        end else if (w_cand_br) begin
            w_win_sel = SEL_BR;
            w_win_tgt = w_cand_br_tgt;
        end else if (w_cand_jump) begin
            w_win_sel = SEL_JUMP;
            w_win_tgt = w_cand_jump_tgt;
        end else begin
            w_win_sel = SEL_SEQ;
            w_win_tgt = {ADDR_WIDTH{1'b0}};
        end
    end

    // Next state, next pending entries and next registered outputs
    always_comb begin
        w_state_nxt         = r_state;
        w_pend_jump_nxt     = r_pend_jump;
        w_pend_br_nxt       = r_pend_br;
        w_pend_trap_nxt     = r_pend_trap;
        w_pend_jump_tgt_nxt = r_pend_jump_tgt;
        w_pend_br_tgt_nxt   = r_pend_br_tgt;
        w_pend_trap_tgt_nxt = r_pend_trap_tgt;
        w_pc_load_nxt       = 1'b0;
        w_pc_sel_nxt        = SEL_SEQ;
        w_pc_target_nxt     = {ADDR_WIDTH{1'b0}};
        w_flush_nxt         = 1'b0;
        w_halted_nxt        = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_pc_load_nxt   = 1'b1;
                w_pc_sel_nxt    = SEL_RESET;
                w_pc_target_nxt = RESET_VECTOR;
                w_flush_nxt     = 1'b1;
                w_pend_jump_nxt = 1'b0;
                w_pend_br_nxt   = 1'b0;
                w_pend_trap_nxt = 1'b0;
                w_state_nxt     = ST_RUN;
            end
            ST_RUN, ST_HALT: begin
                if ((r_state == ST_HALT && io_bus.halt_req) || io_bus.stall) begin
                    // Hold: a live higher-priority redirect kills every lower-priority pending one
                    w_pend_trap_nxt     = w_cand_trap;
                    w_pend_br_nxt       = w_cand_br & ~w_cand_trap;
                    w_pend_jump_nxt     = w_cand_jump & ~w_cand_br & ~w_cand_trap;
                    w_pend_trap_tgt_nxt = w_cand_trap_tgt;
                    w_pend_br_tgt_nxt   = w_cand_br_tgt;
                    w_pend_jump_tgt_nxt = w_cand_jump_tgt;
                    w_halted_nxt        = (r_state == ST_HALT) && io_bus.halt_req;
                    w_state_nxt         = w_halted_nxt ? ST_HALT : ST_RUN;
                end else begin
                    w_pc_load_nxt   = 1'b1;
                    w_pc_sel_nxt    = w_win_sel;
                    w_pc_target_nxt = w_win_tgt;
                    w_flush_nxt     = (w_win_sel != SEL_SEQ);
                    w_pend_jump_nxt = 1'b0;
                    w_pend_br_nxt   = 1'b0;
                    w_pend_trap_nxt = 1'b0;
                    w_state_nxt     = io_bus.halt_req ? ST_HALT : ST_RUN;
                end
            end
            default: begin
                w_state_nxt     = ST_BOOT;
                w_pend_jump_nxt = 1'b0;
                w_pend_br_nxt   = 1'b0;
                w_pend_trap_nxt = 1'b0;
            end
        endcase
    end

    // State, pending and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state         <= ST_BOOT;
            r_pend_jump     <= 1'b0;
            r_pend_br       <= 1'b0;
            r_pend_trap     <= 1'b0;
            r_pend_jump_tgt <= {ADDR_WIDTH{1'b0}};
            r_pend_br_tgt   <= {ADDR_WIDTH{1'b0}};
            r_pend_trap_tgt <= {ADDR_WIDTH{1'b0}};
            r_pc_load       <= 1'b0;
            r_pc_sel        <= SEL_SEQ;
            r_pc_target     <= {ADDR_WIDTH{1'b0}};
            r_flush         <= 1'b0;
            r_halted        <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_pend_jump     <= w_pend_jump_nxt;
            r_pend_br       <= w_pend_br_nxt;
            r_pend_trap     <= w_pend_trap_nxt;
            r_pend_jump_tgt <= w_pend_jump_tgt_nxt;
            r_pend_br_tgt   <= w_pend_br_tgt_nxt;
            r_pend_trap_tgt <= w_pend_trap_tgt_nxt;
            r_pc_load       <= w_pc_load_nxt;
            r_pc_sel        <= w_pc_sel_nxt;
            r_pc_target     <= w_pc_target_nxt;
            r_flush         <= w_flush_nxt;
            r_halted        <= w_halted_nxt;
        end
    end

    assign io_bus.pc_load   = r_pc_load;
    assign io_bus.pc_sel    = r_pc_sel;
    assign io_bus.pc_target = r_pc_target;
    assign io_bus.flush     = r_flush;
    assign io_bus.halted    = r_halted;

`ifdef FETCH_REDIRECT_PERF_EN
    logic                   w_issue;
    logic [2:0]             w_issue_sel;
    logic [COUNT_WIDTH-1:0] r_perf_jump_cnt, r_perf_br_cnt, r_perf_trap_cnt;

    assign w_issue     = ((r_state == ST_RUN) || (r_state == ST_HALT && !io_bus.halt_req)) && !io_bus.stall;
    assign w_issue_sel = w_issue ? w_win_sel : SEL_SEQ;

    // Saturating per-source counters of issued redirects
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_perf_jump_cnt <= {COUNT_WIDTH{1'b0}};
            r_perf_br_cnt   <= {COUNT_WIDTH{1'b0}};
            r_perf_trap_cnt <= {COUNT_WIDTH{1'b0}};
        end else begin
            if (w_issue_sel == SEL_JUMP && r_perf_jump_cnt != {COUNT_WIDTH{1'b1}})
                r_perf_jump_cnt <= r_perf_jump_cnt + COUNT_WIDTH'(1);
            if (w_issue_sel == SEL_BR && r_perf_br_cnt != {COUNT_WIDTH{1'b1}})
                r_perf_br_cnt <= r_perf_br_cnt + COUNT_WIDTH'(1);
            if (w_issue_sel == SEL_TRAP && r_perf_trap_cnt != {COUNT_WIDTH{1'b1}})
                r_perf_trap_cnt <= r_perf_trap_cnt + COUNT_WIDTH'(1);
        end
    end

    assign io_bus.perf_jump_cnt = r_perf_jump_cnt;
    assign io_bus.perf_br_cnt   = r_perf_br_cnt;
    assign io_bus.perf_trap_cnt = r_perf_trap_cnt;
`endif
endmodule
